// File: rtl/fpga_robots_game_sound_pkg.sv
// Shared definitions for the sound/attention sequencer: pattern IDs,
// FSM state encodings and the note table (divisor and length per note).
package fpga_robots_game_sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic {
        PAT_SHORT = 1'b0,
        PAT_LONG  = 1'b1
    } pat_t;

    // Number of notes in each pattern
    localparam logic [1:0] SHORT_NOTES = 2'd1;
    localparam logic [1:0] LONG_NOTES  = 2'd3;

    // Pitch divisors (1..4); the tone rate is roughly 573Hz / D
    localparam logic [2:0] SHORT_N0_DIV = 3'd1;
    localparam logic [2:0] LONG_N0_DIV  = 3'd1;
    localparam logic [2:0] LONG_N1_DIV  = 3'd2;
    localparam logic [2:0] LONG_N2_DIV  = 3'd1;

    // Note lengths in video frames
    localparam logic [5:0] SHORT_N0_LEN = 6'd15;
    localparam logic [5:0] LONG_N0_LEN  = 6'd15;
    localparam logic [5:0] LONG_N1_LEN  = 6'd15;
    localparam logic [5:0] LONG_N2_LEN  = 6'd15;

    function automatic logic [1:0] note_count(input pat_t pat);
        return (pat == PAT_LONG) ? LONG_NOTES : SHORT_NOTES;
    endfunction

    function automatic logic [2:0] note_div(input pat_t pat, input logic [1:0] idx);
        logic [2:0] div;
        div = SHORT_N0_DIV;
        if (pat == PAT_LONG) begin
            case (idx)
                2'd0:    div = LONG_N0_DIV;
                2'd1:    div = LONG_N1_DIV;
                default: div = LONG_N2_DIV;
            endcase
        end
        return div;
    endfunction

    function automatic logic [5:0] note_len(input pat_t pat, input logic [1:0] idx);
        logic [5:0] len;
        len = SHORT_N0_LEN;
        if (pat == PAT_LONG) begin
            case (idx)
                2'd0:    len = LONG_N0_LEN;
                2'd1:    len = LONG_N1_LEN;
                default: len = LONG_N2_LEN;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/fpga_robots_game_sound_pitch_div.sv
// Pitch divider: counts baud8 pulses while a note plays and emits a
// registered one-cycle tone_trigger every D-th pulse.
module sound_pitch_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       baud8,
    input  logic [2:0] divisor,
    output logic       tone_trigger
);

    logic [1:0] div_cnt;
    logic [2:0] div_last;
    logic       at_last;

    // Divisor is always 1..4, so D-1 fits the 2-bit counter range
    assign div_last = divisor - 3'd1;
    assign at_last  = ({1'b0, div_cnt} == div_last);

    // Advance on baud8 while enabled; wrap and fire on the last count
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= 2'd0;
            tone_trigger <= 1'b0;
        end else if (clear) begin
            div_cnt      <= 2'd0;
            tone_trigger <= 1'b0;
        end else begin
            tone_trigger <= 1'b0;
            if (enable && baud8) begin
                if (at_last) begin
                    div_cnt      <= 2'd0;
                    tone_trigger <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fpga_robots_game_sound.sv
// Sound/attention sequencer: plays short/long beep patterns frame by
// frame, holds one pending request, and drives attention and the tone
// trigger pulse train for the sine generator.
module fpga_robots_game_sound
    import fpga_robots_game_sound_pkg::*;
#(
    parameter int GAP_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic framepulse,
    input  logic baud8,
    input  logic want_short,
    input  logic want_long,
    output logic attention,
    output logic tone_trigger,
    output logic busy
);

    localparam logic [5:0] GAP_LOAD = 6'(GAP_FRAMES);

    state_t     state, next_state;
    pat_t       cur_pat, next_pat;
    logic [1:0] note_idx, next_note_idx;
    logic [5:0] frame_cnt, next_frame_cnt;
    logic       pend_valid, next_pend_valid;
    pat_t       pend_pat, next_pend_pat;

    logic       req_any;
    pat_t       req_pat;
    logic       merged_valid;
    pat_t       merged_pat;
    logic       frame_done;
    logic       last_note;
    logic       note_active;
    logic       div_clear;
    logic [2:0] cur_div;

    assign req_any    = want_short | want_long;
    assign req_pat    = want_long ? PAT_LONG : PAT_SHORT;
    assign frame_done = framepulse && (frame_cnt == 6'd1);
    assign last_note  = (note_idx == (note_count(cur_pat) - 2'd1));
    assign cur_div    = note_div(cur_pat, note_idx);

    // The divider is held off on the cycle a note ends so no trigger
    // leaks into the following gap, idle or next pattern
    assign note_active = (state == ST_NOTE) && !frame_done;

    // Fold this cycle's request into the pending slot: long beats short
    always_comb begin
        merged_valid = pend_valid;
        merged_pat   = pend_pat;
        if (req_any) begin
            merged_valid = 1'b1;
            if (!pend_valid || (req_pat == PAT_LONG)) begin
                merged_pat = req_pat;
            end
        end
    end

    // Next-state, frame countdown, note stepping and pending-slot update
    always_comb begin
        next_state      = state;
        next_pat        = cur_pat;
        next_note_idx   = note_idx;
        next_frame_cnt  = frame_cnt;
        next_pend_valid = pend_valid;
        next_pend_pat   = pend_pat;
        div_clear       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    next_state     = ST_NOTE;
                    next_pat       = req_pat;
                    next_note_idx  = 2'd0;
                    next_frame_cnt = note_len(req_pat, 2'd0);
                    div_clear      = 1'b1;
                end
            end

            ST_NOTE: begin
                next_pend_valid = merged_valid;
                next_pend_pat   = merged_pat;
                if (framepulse && (frame_cnt != 6'd0)) begin
                    next_frame_cnt = frame_cnt - 6'd1;
                end
                if (frame_done) begin
                    if (!last_note) begin
                        next_state     = ST_GAP;
                        next_frame_cnt = GAP_LOAD;
                    end else if (merged_valid) begin
                        next_state      = ST_NOTE;
                        next_pat        = merged_pat;
                        next_note_idx   = 2'd0;
                        next_frame_cnt  = note_len(merged_pat, 2'd0);
                        next_pend_valid = 1'b0;
                        div_clear       = 1'b1;
                    end else begin
                        next_state    = ST_IDLE;
                        next_note_idx = 2'd0;
                    end
                end
            end

            ST_GAP: begin
                next_pend_valid = merged_valid;
                next_pend_pat   = merged_pat;
                if (framepulse && (frame_cnt != 6'd0)) begin
                    next_frame_cnt = frame_cnt - 6'd1;
                end
                if (frame_done) begin
                    next_state     = ST_NOTE;
                    next_note_idx  = note_idx + 2'd1;
                    next_frame_cnt = note_len(cur_pat, note_idx + 2'd1);
                    div_clear      = 1'b1;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_pat    <= PAT_SHORT;
            note_idx   <= 2'd0;
            frame_cnt  <= 6'd0;
            pend_valid <= 1'b0;
            pend_pat   <= PAT_SHORT;
        end else begin
            state      <= next_state;
            cur_pat    <= next_pat;
            note_idx   <= next_note_idx;
            frame_cnt  <= next_frame_cnt;
            pend_valid <= next_pend_valid;
            pend_pat   <= next_pend_pat;
        end
    end

    assign attention = (state != ST_IDLE);
    assign busy      = attention | pend_valid;

    sound_pitch_div u_pitch_div (
        .clk          (clk),
        .rst          (rst),
        .clear        (div_clear),
        .enable       (note_active),
        .baud8        (baud8),
        .divisor      (cur_div),
        .tone_trigger (tone_trigger)
    );

endmodule

// File: doc/fpga_robots_game_sound.md
# fpga_robots_game_sound

Sound/attention sequencer that sits between the game play logic and the audio output stage. It accepts short and long beep requests from the play block. It then produces the `attention` level, which the video block uses for its flash and which gates audio, and a `tone_trigger` pulse train that steps the sine-wave generator at a per-note pitch. A short beep is one note. A long beep is a three-note pattern. One further request can be queued while a pattern is playing.

## Interface
Parameters:
- `GAP_FRAMES`, default 3: silent frames between notes of a multi-note pattern (1..15).

Ports:
- `clk`  in  1  system clock (~65MHz).
- `rst`  in  1  reset, synchronous, active-high.
- `framepulse`  in  1  one-cycle pulse per video frame (60Hz).
- `baud8`  in  1  one-cycle pulse at 921.6kHz.
- `want_short`  in  1  one-cycle request: short beep.
- `want_long`  in  1  one-cycle request: long beep.
- `attention`  out  1  high while any pattern is active, including gaps.
- `tone_trigger`  out  1  one-cycle pulse; drives sinewaver `trigger`.
- `busy`  out  1  high when a pattern is active or a request is pending.

## Operation
- Pattern table, indexed by pattern and note; each entry is (divisor D in 1..4, length in frames):
  - Short pattern: note 0 is (D=1, 15 frames).
  - Long pattern: note 0 is (D=1, 15), note 1 is (D=2, 15), note 2 is (D=1, 15).
- State machine states: IDLE, NOTE, GAP.
- IDLE to NOTE: on any request; note index is 0; frame counter is loaded with the note length; pitch divider is cleared.
- NOTE:
  - Every `framepulse` decrements the frame counter.
  - On the `framepulse` that takes the counter from 1 to 0: go to GAP if further notes remain (counter loaded with `GAP_FRAMES`); otherwise go to IDLE, or to NOTE for the pending request if one exists.
- GAP:
  - Same countdown.
  - At 0: note index increments and the state goes to NOTE with that note's length; pitch divider is cleared.
- Pitch divider:
  - 2-bit counter that advances on `baud8` in NOTE only.
  - When the counter equals D-1 on a `baud8` pulse, `tone_trigger` fires and the counter wraps to 0.
  - Resulting pitch is about 573Hz/D.
- Requests:
  - When both request lines are high in the same cycle, long wins.
  - A request arriving while not IDLE is written into a 1-entry pending slot. Long overwrites short; short never overwrites long.
  - A second short on a pending short is absorbed.
  - The pending slot is consumed and cleared when the current pattern ends. The next pattern starts with no IDLE cycle in between.
- A request arriving in the same cycle as the final `framepulse` of a pattern goes to the pending slot and starts immediately.
- `attention` = (state != IDLE). `busy` = `attention` or pending valid.

## Timing
- Reset values: every output is 0. State is IDLE, pending slot empty, all counters 0.
- Reset mid-pattern: silence and `attention` low on the first cycle after `rst`. The pending request is discarded.
- Request-to-`attention` latency is 1 cycle, because `attention` is registered.
- `tone_trigger` is registered. It asserts 1 cycle after the qualifying `baud8` and is never high for 2 consecutive cycles.
- Note length: a note entered mid-frame lasts between N-1 and N full frames, where N is the table length.
- No `tone_trigger` fires in GAP or IDLE, including on the transition cycle out of NOTE.
- Width rules:
  - Frame counter is 6 bits and loaded directly.
  - Note index is 2 bits.
  - No arithmetic wraps except the pitch divider.

## Structure
- The shared package holds:
  - pattern IDs (`PAT_SHORT`, `PAT_LONG`),
  - state encodings,
  - the pattern table as constants (note count per pattern, divisor and length per note).
- Sub-module `sound_pitch_div`: the 2-bit `baud8` divider with clear and divisor inputs, producing the registered `tone_trigger`.
- The FSM, pending slot and frame counter stay in the top module.
- The top-level atnctr logic is replaced: `attention` comes from here, and `tone_trigger` replaces `attention && baud8`.

## Test plan
- Short beep:
  - Stimulus: `want_short` pulse from IDLE.
  - Required: `attention` high from cycle +1 for 14-15 frames; `tone_trigger` count equals the count of `baud8` pulses in NOTE; `busy` falls together with `attention`.
- Long beep:
  - Stimulus: `want_long` pulse.
  - Required: note 1 has half the trigger rate of notes 0 and 2; 3-frame gaps with 0 triggers; `attention` stays high across gaps, about 51 frames total.
- Simultaneous requests:
  - Stimulus: `want_short` and `want_long` in the same cycle.
  - Required: the long pattern plays and nothing is left pending.
- Queueing:
  - Stimulus: during a short beep, send `want_short` then `want_long`.
  - Required: after the short ends, a long starts with no IDLE cycle; then IDLE; `busy` drops once.
- Reset mid-pattern:
  - Stimulus: `rst` asserted in GAP of a long beep with a short pending.
  - Required: all outputs 0 next cycle; no beep follows deassertion.
- End-of-pattern collision:
  - Stimulus: `want_short` on the final `framepulse` of a short.
  - Required: a second short plays back-to-back with `attention` continuously high.
